// File: rtl/ifu_pkg.sv
// ifu_pkg: shared types, default widths and redirect target helpers for the
// instruction fetch unit.
//   ifu_state_t    - fetch FSM state (IDLE / RUN / DONE)
//   IFU_* params   - default widths and depths used by instr_fetch_unit
//   branch_target  - relative redirect: lastPc + 1 + signed offset
//   jump_target    - page-absolute redirect: low field bits replace lastPc bits
// The helpers work on 32-bit values; callers size-cast to PC_W (PC_W <= 32).
package ifu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } ifu_state_t;

  localparam int IFU_INSTR_W   = 16;
  localparam int IFU_DEPTH     = 256;
  localparam int IFU_PC_W      = 16;
  localparam int IFU_BR_OFF_W  = 6;
  localparam int IFU_JMP_W     = 12;
  localparam int IFU_BUF_DEPTH = 2;

  function automatic logic [31:0] branch_target(input logic [31:0]        lastPc,
                                                input logic signed [31:0] offset);
    return lastPc + 32'd1 + $unsigned(offset);
  endfunction

  function automatic logic [31:0] jump_target(input logic [31:0] lastPc,
                                              input logic [31:0] field,
                                              input int          fieldW);
    logic [31:0] mask;
    mask = (32'd1 << fieldW) - 32'd1;
    return (lastPc & ~mask) | (field & mask);
  endfunction

endpackage

// File: rtl/ifu_prefetch_buf.sv
// ifu_prefetch_buf: small FIFO holding prefetched {pc, instruction} entries.
// Ports:
//   clk, resetInstructionMemory (async, active-high)
//   flush      - empties the FIFO this edge (takes priority over write/read)
//   wrEn/wrData- push one entry (ignored when full)
//   rdEn       - pop the head entry (ignored when empty)
//   headData   - current head entry
//   empty/full - status
//   occupancy  - number of stored entries, width $clog2(DEPTH)+1
// Storage is not reset; only pointers and the counter are.
module ifu_prefetch_buf #(
  parameter int W     = 32,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     resetInstructionMemory,
  input  logic                     flush,
  input  logic                     wrEn,
  input  logic [W-1:0]             wrData,
  input  logic                     rdEn,
  output logic [W-1:0]             headData,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  store [DEPTH];
  logic [PW-1:0] wrPtr;
  logic [PW-1:0] rdPtr;
  logic          doWr;
  logic          doRd;

  assign empty    = (occupancy == '0);
  assign full     = (occupancy == (PW+1)'(DEPTH));
  assign doWr     = wrEn & ~full & ~flush;
  assign doRd     = rdEn & ~empty & ~flush;
  assign headData = store[rdPtr];

  always_ff @(posedge clk) begin
    if (doWr) store[wrPtr] <= wrData;
  end

  always_ff @(posedge clk or posedge resetInstructionMemory) begin
    if (resetInstructionMemory) begin
      wrPtr     <= '0;
      rdPtr     <= '0;
      occupancy <= '0;
    end else if (flush) begin
      wrPtr     <= '0;
      rdPtr     <= '0;
      occupancy <= '0;
    end else begin
      if (doWr) wrPtr <= wrPtr + PW'(1);
      if (doRd) rdPtr <= rdPtr + PW'(1);
      occupancy <= occupancy + {{PW{1'b0}}, doWr} - {{PW{1'b0}}, doRd};
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: program ROM + fetch PC + prefetch buffer, presenting
// instructions over a valid/ready handshake and resolving branch/jump redirects.
// Optional build macro: IFU_WRITE_PORT_EN adds a synchronous memory write port.
// Ports:
//   clk, resetInstructionMemory (async, active-high)
//   fetch_en, prog_len            - fetch control and program length
//   instr_valid/instr_ready       - output handshake
//   instr_data, instr_pc          - head instruction and its address (0 when not valid)
//   branch_en, branch_offset      - relative redirect pulse
//   jump_en, jump_target          - page-absolute redirect pulse (jump wins)
//   redirect_done                 - one-cycle pulse after an accepted redirect
//   done                          - program exhausted and pipeline empty
//   imem_we/imem_waddr/imem_wdata - write port (IFU_WRITE_PORT_EN only)
module instr_fetch_unit
  import ifu_pkg::*;
#(
  parameter int INSTR_W   = IFU_INSTR_W,
  parameter int DEPTH     = IFU_DEPTH,
  parameter int PC_W      = IFU_PC_W,
  parameter int BR_OFF_W  = IFU_BR_OFF_W,
  parameter int JMP_W     = IFU_JMP_W,
  parameter int BUF_DEPTH = IFU_BUF_DEPTH,
  parameter     INIT_FILE = "test/test.prog"
) (
  input  logic                clk,
  input  logic                resetInstructionMemory,
  input  logic                fetch_en,
  input  logic [PC_W-1:0]     prog_len,
  output logic                instr_valid,
  input  logic                instr_ready,
  output logic [INSTR_W-1:0]  instr_data,
  output logic [PC_W-1:0]     instr_pc,
  input  logic                branch_en,
  input  logic [BR_OFF_W-1:0] branch_offset,
  input  logic                jump_en,
  input  logic [JMP_W-1:0]    jump_target,
  output logic                redirect_done,
  output logic                done
`ifdef IFU_WRITE_PORT_EN
  ,
  input  logic                imem_we,
  input  logic [PC_W-1:0]     imem_waddr,
  input  logic [INSTR_W-1:0]  imem_wdata
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int OW = $clog2(BUF_DEPTH) + 1;
  localparam int EW = PC_W + INSTR_W;

  logic [INSTR_W-1:0] imem [DEPTH];

  ifu_state_t state;
  ifu_state_t stateNext;

  logic [PC_W-1:0]            fpc;
  logic [PC_W-1:0]            lastPc;
  logic                       epoch;
  logic                       redirect;
  logic                       handshake;
  logic                       issue;
  logic                       tgtInRange;
  logic signed [BR_OFF_W-1:0] brOff;
  logic [PC_W-1:0]            brTgt;
  logic [PC_W-1:0]            jmpTgt;
  logic [PC_W-1:0]            redirTgt;

  logic                       rdVld_p1;
  logic                       rdEpoch_p1;
  logic [INSTR_W-1:0]         rdData_p1;
  logic [PC_W-1:0]            rdPc_p1;

  logic                       bufWr;
  logic                       bufEmpty;
  logic                       unusedBufFull;
  logic [OW-1:0]              bufOcc;
  logic [EW-1:0]              bufHead;
  logic [OW:0]                pending;
  logic [OW:0]                limit;

`ifdef IFU_WRITE_PORT_EN
  logic [PC_W-1:0] unusedWaddr;
  assign unusedWaddr = imem_waddr;

  // Nonblocking write: a same-edge read of this address still sees old data.
  always_ff @(posedge clk) begin
    if (imem_we) imem[imem_waddr[AW-1:0]] <= imem_wdata;
  end
`endif

  assign handshake  = instr_valid & instr_ready;
  assign redirect   = (state != IDLE) & (branch_en | jump_en);
  assign brOff      = branch_offset;
  assign brTgt      = PC_W'(ifu_pkg::branch_target(32'(lastPc), 32'(brOff)));
  assign jmpTgt     = PC_W'(ifu_pkg::jump_target(32'(lastPc), 32'(jump_target), JMP_W));
  assign redirTgt   = jump_en ? jmpTgt : brTgt;
  assign tgtInRange = (redirTgt < prog_len);

  // A word popped this cycle frees a slot, so steady-state streaming keeps
  // one word buffered and one in flight without a bubble.
  assign pending = {1'b0, bufOcc} + {{OW{1'b0}}, rdVld_p1};
  assign limit   = (OW+1)'(BUF_DEPTH) + {{OW{1'b0}}, handshake};
  assign issue   = (state == RUN) & fetch_en & (fpc < prog_len) & (pending < limit);

  // Reads launched before a redirect carry the old epoch and are dropped;
  // the one landing on the redirect edge itself is dropped explicitly.
  assign bufWr = rdVld_p1 & (rdEpoch_p1 == epoch) & ~redirect;

  always_ff @(posedge clk or posedge resetInstructionMemory) begin
    if (resetInstructionMemory) state <= IDLE;
    else                        state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (fetch_en) stateNext = RUN;
      RUN:     if (!redirect && (fpc >= prog_len) && !rdVld_p1 && bufEmpty) stateNext = DONE;
      DONE:    if (redirect && tgtInRange) stateNext = RUN;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge resetInstructionMemory) begin
    if (resetInstructionMemory) begin
      fpc           <= '0;
      lastPc        <= '0;
      epoch         <= 1'b0;
      rdVld_p1      <= 1'b0;
      rdEpoch_p1    <= 1'b0;
      redirect_done <= 1'b0;
    end else begin
      rdVld_p1      <= issue;
      rdEpoch_p1    <= epoch;
      redirect_done <= redirect;
      if (handshake) lastPc <= instr_pc;
      if (redirect) begin
        fpc   <= redirTgt;
        epoch <= ~epoch;
      end else if (issue) begin
        fpc   <= fpc + PC_W'(1);
      end
    end
  end

  // ---- stage p0 -> p1: synchronous ROM read ----
  always_ff @(posedge clk) begin
    if (issue) begin
      rdData_p1 <= imem[fpc[AW-1:0]];
      rdPc_p1   <= fpc;
    end
  end

  // ---- stage p1 -> buffer ----
  ifu_prefetch_buf #(
    .W     (EW),
    .DEPTH (BUF_DEPTH)
  ) u_buf (
    .clk                    (clk),
    .resetInstructionMemory (resetInstructionMemory),
    .flush                  (redirect),
    .wrEn                   (bufWr),
    .wrData                 ({rdPc_p1, rdData_p1}),
    .rdEn                   (handshake),
    .headData               (bufHead),
    .empty                  (bufEmpty),
    .full                   (unusedBufFull),
    .occupancy              (bufOcc)
  );

  assign instr_valid            = ~bufEmpty;
  assign {instr_pc, instr_data} = instr_valid ? bufHead : '0;
  assign done                   = (state == DONE);

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        resetInstructionMemory;
  logic        fetch_en;
  logic [15:0] prog_len;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr_data;
  logic [15:0] instr_pc;
  logic        branch_en;
  logic [5:0]  branch_offset;
  logic        jump_en;
  logic [11:0] jump_target;
  logic        redirect_done;
  logic        done;
`ifdef IFU_WRITE_PORT_EN
  logic        imem_we;
  logic [15:0] imem_waddr;
  logic [15:0] imem_wdata;
`endif

  always #5 clk = ~clk;

  instr_fetch_unit #(.INIT_FILE("")) dut (
    .clk                    (clk),
    .resetInstructionMemory (resetInstructionMemory),
    .fetch_en               (fetch_en),
    .prog_len               (prog_len),
    .instr_valid            (instr_valid),
    .instr_ready            (instr_ready),
    .instr_data             (instr_data),
    .instr_pc               (instr_pc),
    .branch_en              (branch_en),
    .branch_offset          (branch_offset),
    .jump_en                (jump_en),
    .jump_target            (jump_target),
    .redirect_done          (redirect_done),
    .done                   (done)
`ifdef IFU_WRITE_PORT_EN
    ,
    .imem_we                (imem_we),
    .imem_waddr             (imem_waddr),
    .imem_wdata             (imem_wdata)
`endif
  );

  typedef struct {
    logic [15:0] pc;
    logic [15:0] data;
  } exp_t;

  exp_t sbq[$];
  exp_t monE;
  int   total = 0;
  int   bad   = 0;

  task automatic chkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Image word at address a is a+1 (low 8 address bits index the ROM).
  task automatic pushRange(input int start, input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.pc   = 16'(start + i);
      e.data = {8'h00, e.pc[7:0]} + 16'd1;
      sbq.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    if (!resetInstructionMemory && instr_valid && instr_ready) begin
      if (sbq.size() == 0) begin
        chkVal("sb_pending", 32'(sbq.size()), 32'd1);
      end else begin
        monE = sbq.pop_front();
        chkVal("sb_pc", 32'(instr_pc), 32'(monE.pc));
        chkVal("sb_data", 32'(instr_data), 32'(monE.data));
      end
    end
  end

  task automatic startFetch(input string tag);
    fetch_en = 1'b1;
    tick();
    chkVal({tag, "_lat1"}, 32'(instr_valid), 32'd0);
    tick();
    chkVal({tag, "_lat2"}, 32'(instr_valid), 32'd0);
    tick();
    chkVal({tag, "_lat3"}, 32'(instr_valid), 32'd1);
    chkVal({tag, "_pc0"}, 32'(instr_pc), 32'd0);
  endtask

  task automatic waitDone(input string tag);
    for (int i = 0; i < 40 && !done; i++) tick();
    chkVal({tag, "_done"}, 32'(done), 32'd1);
    chkVal({tag, "_sbq"}, 32'(sbq.size()), 32'd0);
    chkVal({tag, "_valid"}, 32'(instr_valid), 32'd0);
  endtask

  task automatic waitPc(input string tag, input logic [15:0] pc, input int limit);
    for (int i = 0; i < limit && !(instr_valid && instr_pc == pc); i++) tick();
    chkVal({tag, "_seen"}, 32'(instr_pc), 32'(pc));
  endtask

  task automatic waitEmpty(input string tag);
    for (int i = 0; i < 40 && sbq.size() != 0; i++) tick();
    instr_ready = 1'b0;
    chkVal({tag, "_sbq"}, 32'(sbq.size()), 32'd0);
  endtask

  task automatic doReset();
    resetInstructionMemory = 1'b1;
    fetch_en = 1'b0;
    tick();
    resetInstructionMemory = 1'b0;
    sbq.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, total=%0d", total);
    $fatal(1, "watchdog");
  end

  initial begin
    resetInstructionMemory = 1'b1;
    fetch_en      = 1'b0;
    prog_len      = 16'd0;
    instr_ready   = 1'b0;
    branch_en     = 1'b0;
    branch_offset = 6'd0;
    jump_en       = 1'b0;
    jump_target   = 12'd0;
`ifdef IFU_WRITE_PORT_EN
    imem_we    = 1'b0;
    imem_waddr = 16'd0;
    imem_wdata = 16'd0;
    for (int i = 0; i < 256; i++) begin
      imem_we    = 1'b1;
      imem_waddr = 16'(i);
      imem_wdata = 16'(i + 1);
      tick();
    end
    imem_we = 1'b0;
`else
    for (int i = 0; i < 256; i++) dut.imem[i] = 16'(i + 1);
`endif
    repeat (2) tick();

    chkVal("rst_valid", 32'(instr_valid), 32'd0);
    chkVal("rst_data", 32'(instr_data), 32'd0);
    chkVal("rst_pc", 32'(instr_pc), 32'd0);
    chkVal("rst_rdone", 32'(redirect_done), 32'd0);
    chkVal("rst_done", 32'(done), 32'd0);
    resetInstructionMemory = 1'b0;
    tick();

    // Five-word program streamed with ready held high.
    prog_len    = 16'd5;
    instr_ready = 1'b1;
    pushRange(0, 5);
    startFetch("seq");
    for (int k = 1; k < 5; k++) begin
      tick();
      chkVal("seq_nobubble", 32'(instr_valid), 32'd1);
    end
    waitDone("seq");

    // Redirect out of DONE: lastPc=4, offset -3 -> target 2.
    branch_offset = 6'b111101;
    branch_en     = 1'b1;
    pushRange(2, 3);
    tick();
    branch_en = 1'b0;
    chkVal("dr_rdone", 32'(redirect_done), 32'd1);
    chkVal("dr_state", 32'(done), 32'd0);
    tick();
    chkVal("dr_rdone_low", 32'(redirect_done), 32'd0);
    tick();
    chkVal("dr_valid", 32'(instr_valid), 32'd1);
    waitDone("dr");

    // Backpressure: head must hold while ready is low.
    doReset();
    instr_ready = 1'b0;
    prog_len    = 16'd8;
    pushRange(0, 8);
    startFetch("bp");
    for (int k = 0; k < 4; k++) begin
      tick();
      chkVal("bp_valid", 32'(instr_valid), 32'd1);
      chkVal("bp_pc", 32'(instr_pc), 32'd0);
      chkVal("bp_data", 32'(instr_data), 32'd1);
    end
    instr_ready = 1'b1;
    waitDone("bp");

    // Branch after accepting pc 3 with offset -2.
    doReset();
    prog_len    = 16'd8;
    instr_ready = 1'b1;
    pushRange(0, 4);
    fetch_en = 1'b1;
    waitPc("br", 16'd3, 20);
    tick();
    instr_ready   = 1'b0;
    branch_en     = 1'b1;
    branch_offset = 6'b111110;
    chkVal("br_sbq", 32'(sbq.size()), 32'd0);
    pushRange(2, 6);
    tick();
    branch_en = 1'b0;
    chkVal("br_rdone", 32'(redirect_done), 32'd1);
    chkVal("br_valid_r", 32'(instr_valid), 32'd0);
    tick();
    chkVal("br_valid_r1", 32'(instr_valid), 32'd0);
    tick();
    chkVal("br_valid_r2", 32'(instr_valid), 32'd1);
    chkVal("br_pc", 32'(instr_pc), 32'd2);
    instr_ready = 1'b1;
    waitDone("br");

    // Jump from pc 0x1003 with a simultaneous branch that must be ignored.
    doReset();
    prog_len    = 16'h2000;
    instr_ready = 1'b1;
    pushRange(0, 16'h1004);
    startFetch("jmp");
    waitPc("jmp", 16'h1003, 5000);
    tick();
    instr_ready   = 1'b0;
    jump_en       = 1'b1;
    jump_target   = 12'h040;
    branch_en     = 1'b1;
    branch_offset = 6'd5;
    chkVal("jmp_sbq0", 32'(sbq.size()), 32'd0);
    pushRange(16'h1040, 4);
    tick();
    jump_en   = 1'b0;
    branch_en = 1'b0;
    chkVal("jmp_rdone", 32'(redirect_done), 32'd1);
    tick();
    tick();
    chkVal("jmp_valid", 32'(instr_valid), 32'd1);
    chkVal("jmp_pc", 32'(instr_pc), 32'h1040);
    instr_ready = 1'b1;
    waitEmpty("jmp");

    // Asynchronous reset between clock edges while a word is presented.
    tick();
    chkVal("ar_pre_valid", 32'(instr_valid), 32'd1);
    #2;
    resetInstructionMemory = 1'b1;
    #1;
    chkVal("ar_valid", 32'(instr_valid), 32'd0);
    chkVal("ar_pc", 32'(instr_pc), 32'd0);
    chkVal("ar_rdone", 32'(redirect_done), 32'd0);
    fetch_en = 1'b0;
    tick();
    resetInstructionMemory = 1'b0;
    sbq.delete();
    prog_len    = 16'd5;
    instr_ready = 1'b1;
    pushRange(0, 5);
    startFetch("ar");
    waitDone("ar");

`ifdef IFU_WRITE_PORT_EN
    // Overwrite address 7 and jump there from DONE (lastPc=4).
    imem_we    = 1'b1;
    imem_waddr = 16'd7;
    imem_wdata = 16'hBEEF;
    tick();
    imem_we     = 1'b0;
    prog_len    = 16'd20;
    jump_en     = 1'b1;
    jump_target = 12'd7;
    begin
      exp_t e;
      e.pc   = 16'd7;
      e.data = 16'hBEEF;
      sbq.push_back(e);
    end
    pushRange(8, 2);
    tick();
    jump_en = 1'b0;
    tick();
    tick();
    chkVal("wp_valid", 32'(instr_valid), 32'd1);
    chkVal("wp_data", 32'(instr_data), 32'h0000BEEF);
    waitEmpty("wp");
`endif

    repeat (3) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Parametrised instruction fetch unit that supersedes the single-word, event-triggered instruction store. Holds the program image in a synchronous ROM and owns the fetch PC. Prefetches sequentially into a small buffer and presents instructions to the control unit over a valid/ready handshake. Resolves branch (relative) and jump (page-absolute) redirects with buffer flush and stale-read suppression.

## Interface
- INSTR_W, 16, instruction width in bits
- DEPTH, 256, memory depth in words (power of two)
- PC_W, 16, program counter width
- BR_OFF_W, 6, branch offset width (two's complement)
- JMP_W, 12, jump target field width (JMP_W < PC_W)
- BUF_DEPTH, 2, prefetch buffer entries (power of two, ≥ 2)
- INIT_FILE, "test/test.prog", $readmemb image loaded at elaboration
- clk  in  1  clock, rising edge
- resetInstructionMemory  in  1  reset, asynchronous, active-high
- fetch_en  in  1  level; start/continue fetching
- prog_len  in  PC_W  number of valid program words; sequential fetch stops at this address
- instr_valid  out  1  instr_data/instr_pc valid
- instr_ready  in  1  consumer accepts when high with instr_valid
- instr_data  out  INSTR_W  instruction word
- instr_pc  out  PC_W  address of instr_data
- branch_en  in  1  one-cycle redirect pulse, relative
- branch_offset  in  BR_OFF_W  signed offset
- jump_en  in  1  one-cycle redirect pulse, absolute within page
- jump_target  in  JMP_W  low PC bits of jump destination
- redirect_done  out  1  one-cycle pulse, redirect accepted
- done  out  1  program exhausted, pipeline empty

## Operation
- States: IDLE, RUN, DONE. Reset → IDLE. IDLE→RUN when fetch_en=1. RUN→DONE when fpc ≥ prog_len, no read in flight, buffer empty. DONE→RUN on any redirect whose target < prog_len. fetch_en=0 in RUN stops new reads; buffered words still drain.
- fetch PC fpc; memory index fpc[$clog2(DEPTH)-1:0] (silent wrap above DEPTH).
- Read issued in RUN when fpc < prog_len and (occupancy + in-flight) < BUF_DEPTH; fpc <= fpc+1 (mod 2^PC_W).
- last_pc: instr_pc of the most recent handshake (instr_valid & instr_ready); reset 0.
- Branch target = last_pc + 1 + sign_extend(branch_offset), mod 2^PC_W.
- Jump target = {last_pc[PC_W-1:JMP_W], jump_target}.
- branch_en and jump_en together: jump wins, branch ignored.
- Redirect: fpc <= target, buffer cleared, epoch bit toggled; returning read tagged with old epoch is discarded. A handshake in the redirect cycle completes and updates last_pc, but the target is computed from last_pc before that update.
- Buffer FIFO; head drives instr_data/instr_pc; full/empty from occupancy counter of width $clog2(BUF_DEPTH)+1.

## Timing
- Reset values: instr_valid 0, instr_data 0, instr_pc 0, redirect_done 0, done 0; fpc 0, occupancy 0, epoch 0, state IDLE.
- Memory read latency 1 cycle; write to buffer on the following edge.
- From fetch_en sampled high in IDLE: read at edge E+1, instr_valid at E+2.
- Steady state with instr_ready held 1: one instruction per cycle, no bubbles.
- Redirect sampled at edge R: redirect_done high R→R+1, instr_valid low from R, target read at R+1, target word valid at R+2.
- instr_data/instr_pc stable while instr_valid=1 and instr_ready=0.
- Reset mid-operation: all state cleared immediately, in-flight read discarded.

## Configuration
- IFU_WRITE_PORT_EN defined: adds imem_we (in, 1), imem_waddr (in, PC_W), imem_wdata (in, INSTR_W). Synchronous write on clk; read-during-write to the same address returns old data. Writes do not update the buffer; software issues a redirect to refetch.
- Undefined: memory is read-only after INIT_FILE load; ports absent.

## Structure
- Package ifu_pkg: state enum (IDLE/RUN/DONE), default widths, target-calculation functions (branch_target, jump_target).
- One sub-module: ifu_prefetch_buf (parametrised FIFO with flush, occupancy, head outputs).

## Test plan
- Image 0x0001..0x0005, prog_len=5, ready=1: five words at pc 0..4 on consecutive cycles, then done=1; no word for pc 5.
- Backpressure: ready=0 for 4 cycles after first valid: instr_pc stays 0, at most BUF_DEPTH reads issued, no word lost or duplicated.
- Branch after accepting pc 3, offset=−2 (6'b111110): next accepted instr_pc=2, stale pc 4/5 words never presented.
- Jump with last_pc=0x1003, jump_target=0x040: next instr_pc=0x1040; same-cycle branch_en ignored.
- Async reset asserted mid-stream between edges: instr_valid 0 immediately; fetch restarts at pc 0 two cycles after fetch_en.
- IFU_WRITE_PORT_EN: write 0xBEEF to addr 7, jump to 7: instr_data=0xBEEF.
